// File: rtl/ex_stage.sv
// Execute stage for the 16-bit core. Operands are registered into the external ALU and its result is captured for writeback.
// OP_DIV bypasses the ALU and runs on a 16-iteration restoring divider.
module ex_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_rd,
  input  logic             in_setflags,
  output logic [4:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_nzcv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_rd,
  output logic             out_we,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_SHL = 5'd5;
  localparam logic [4:0] OP_SHR = 5'd6;
  localparam logic [4:0] OP_MOV = 5'd7;
  localparam logic [4:0] OP_CMP = 5'd8;
  localparam logic [4:0] OP_DIV = 5'd9;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, HOLD} state_t;

  state_t           state;
  logic [4:0]       op_q;
  logic [3:0]       rd_q;
  logic             sf_q;
  logic [WIDTH-1:0] quo, rem, dvsr;
  logic [3:0]       cnt;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;
  logic             known, arith;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  // A zero divisor always "fits", which yields an all-ones quotient for free.
  always_comb begin
    rem_sh  = {rem, quo[WIDTH-1]};
    diff    = {1'b0, rem_sh} - {2'b00, dvsr};
    ge      = ~diff[WIDTH+1];
    quo_nxt = {quo[WIDTH-2:0], ge};
    rem_nxt = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  end

  always_comb begin
    known = 1'b0;
    arith = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_CMP: begin known = 1'b1; arith = 1'b1; end
      OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MOV: known = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      sf_q       <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      dvsr       <= '0;
      cnt        <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_we     <= 1'b0;
      flags      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q <= in_op;
          rd_q <= in_rd;
          sf_q <= in_setflags;
          if (in_op == OP_DIV) begin
            quo   <= in_a;
            rem   <= '0;
            dvsr  <= in_b;
            cnt   <= '0;
            state <= DIV;
          end else begin
            alu_op <= in_op;
            alu_a  <= in_a;
            alu_b  <= in_b;
            state  <= EXEC;
          end
        end
        EXEC: begin
          out_rd     <= rd_q;
          out_valid  <= 1'b1;
          out_result <= known ? alu_result : '0;
          out_we     <= known && (op_q != OP_CMP);
          if (sf_q && known)
            flags <= arith ? alu_nzcv
                           : {alu_result[WIDTH-1], alu_result == '0, flags[1:0]};
          state      <= HOLD;
        end
        DIV: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            out_result <= quo_nxt;
            out_rd     <= rd_q;
            out_we     <= 1'b1;
            out_valid  <= 1'b1;
            if (sf_q)
              flags <= {quo_nxt[WIDTH-1], quo_nxt == '0, 1'b0, dvsr == '0};
            state      <= HOLD;
          end
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed operations push expectations, a monitor checks each emitted result.
// A small behavioural ALU closes the loop on the alu_* ports.
module tb_ex_stage;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                         OP_XOR = 5'd4, OP_SHL = 5'd5, OP_SHR = 5'd6, OP_MOV = 5'd7,
                         OP_CMP = 5'd8, OP_DIV = 5'd9, OP_BAD = 5'd31;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_setflags = 1'b0;
  logic [4:0] in_op = '0, alu_op;
  logic [15:0] in_a = '0, in_b = '0, alu_a, alu_b, alu_result, out_result;
  logic [3:0] in_rd = '0, alu_nzcv, out_rd, flags;
  logic out_valid, out_ready = 1'b1, out_we, busy;

  ex_stage #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_setflags(in_setflags),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_nzcv(alu_nzcv), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU; C on subtract means "no borrow".
  always_comb begin
    logic [16:0] s;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (alu_op)
      OP_ADD: begin s = {1'b0, alu_a} + {1'b0, alu_b}; c = s[16];
                    v = (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]); end
      OP_SUB, OP_CMP: begin s = {1'b0, alu_a - alu_b}; c = (alu_a >= alu_b);
                    v = (alu_a[15] != alu_b[15]) && (s[15] != alu_a[15]); end
      OP_AND: s = {1'b0, alu_a & alu_b};
      OP_OR:  s = {1'b0, alu_a | alu_b};
      OP_XOR: s = {1'b0, alu_a ^ alu_b};
      OP_SHL: s = {1'b0, alu_a << alu_b[3:0]};
      OP_SHR: s = {1'b0, alu_a >> alu_b[3:0]};
      OP_MOV: s = {1'b0, alu_b};
      default: s = '0;
    endcase
    alu_result = s[15:0];
    alu_nzcv   = {s[15], s[15:0] == 16'h0, c, v};
  end

  typedef struct {
    string       name;
    logic [15:0] result;
    logic [3:0]  rd;
    logic        we;
    logic [3:0]  flags;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each rising out_valid pops one expectation.
  always @(negedge clk) begin
    if (rst) prev_valid <= 1'b0;
    else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 16'd1, 16'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, ".result"}, out_result, e.result);
          check({e.name, ".rd"}, {12'h0, out_rd}, {12'h0, e.rd});
          check({e.name, ".we"}, {15'h0, out_we}, {15'h0, e.we});
          check({e.name, ".flags"}, {12'h0, flags}, {12'h0, e.flags});
          check({e.name, ".latency"}, 16'(cyc + 1 - e.acc), 16'(e.lat));
        end
      end
      prev_valid <= out_valid;
    end
  end

  // Drive one op from a negedge; returns after the accepting edge, at the following negedge.
  task automatic issue(input string name, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] rd, input logic sf,
                       input logic [15:0] er, input logic ewe, input logic [3:0] ef,
                       input bit push);
    int t;
    exp_t e;
    in_op = op; in_a = a; in_b = b; in_rd = rd; in_setflags = sf; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) check({name, ".accept_timeout"}, 16'd0, 16'd1);
    e.name = name; e.result = er; e.rd = rd; e.we = ewe; e.flags = ef;
    e.lat = (op == OP_DIV) ? 17 : 2;
    e.acc = cyc + 1;
    if (push) sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int t;
    t = 0;
    while (busy && t < max) begin @(negedge clk); t++; end
    if (busy) check("drain_timeout", 16'd1, 16'd0);
    @(negedge clk);
  endtask

  initial begin
    int nb;
    logic [15:0] hr;
    logic [3:0]  hd;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.in_ready", {15'h0, in_ready}, 16'd1);
    check("reset.busy", {15'h0, busy}, 16'd0);
    check("reset.out_valid", {15'h0, out_valid}, 16'd0);
    check("reset.flags", {12'h0, flags}, 16'd0);
    check("reset.out_result", out_result, 16'd0);
    check("reset.alu_a", alu_a, 16'd0);

    issue("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 4'd3, 1'b1, 16'h8000, 1'b1, 4'b1001, 1'b1);
    drain(50);
    issue("cmp_eq", OP_CMP, 16'd5, 16'd5, 4'd4, 1'b1, 16'h0000, 1'b0, 4'b0110, 1'b1);
    drain(50);

    issue("div_100_7", OP_DIV, 16'd100, 16'd7, 4'd5, 1'b1, 16'd14, 1'b1, 4'b0000, 1'b1);
    nb = 1;  // already one busy cycle behind us
    while (busy && nb < 100) begin @(negedge clk); if (busy) nb++; end
    check("div.busy_cycles", 16'(nb), 16'd17);
    @(negedge clk);

    issue("div_by_zero", OP_DIV, 16'd1234, 16'd0, 4'd6, 1'b1, 16'hFFFF, 1'b1, 4'b1001, 1'b1);
    drain(100);
    issue("and_keep_cv", OP_AND, 16'hF0F0, 16'h0FF0, 4'd7, 1'b1, 16'h00F0, 1'b1, 4'b0001, 1'b1);
    drain(50);
    issue("sub_neg", OP_SUB, 16'd3, 16'd5, 4'd8, 1'b1, 16'hFFFE, 1'b1, 4'b1000, 1'b1);
    drain(50);
    issue("unknown_op", OP_BAD, 16'h1111, 16'h2222, 4'd2, 1'b1, 16'h0000, 1'b0, 4'b1000, 1'b1);
    drain(50);
    issue("xor_zero", OP_XOR, 16'h1234, 16'h1234, 4'd1, 1'b1, 16'h0000, 1'b1, 4'b0100, 1'b1);
    drain(50);

    out_ready = 1'b0;
    issue("add_bp", OP_ADD, 16'd3, 16'd4, 4'd9, 1'b0, 16'd7, 1'b1, 4'b0100, 1'b1);
    nb = 0;
    while (!out_valid && nb < 50) begin @(negedge clk); nb++; end
    hr = out_result; hd = out_rd;
    repeat (5) begin
      @(negedge clk);
      check("bp.result_stable", out_result, 16'd7);
      check("bp.rd_stable", {12'h0, out_rd}, {12'h0, hd});
      check("bp.valid_held", {15'h0, out_valid}, 16'd1);
      check("bp.in_ready_low", {15'h0, in_ready}, 16'd0);
    end
    check("bp.first_result", hr, 16'd7);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.idle_after_release", {15'h0, in_ready}, 16'd1);
    check("bp.valid_dropped", {15'h0, out_valid}, 16'd0);

    issue("div_abort", OP_DIV, 16'd100, 16'd7, 4'd5, 1'b1, 16'd0, 1'b0, 4'b0, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.in_ready", {15'h0, in_ready}, 16'd1);
    check("abort.busy", {15'h0, busy}, 16'd0);
    check("abort.out_valid", {15'h0, out_valid}, 16'd0);
    check("abort.flags", {12'h0, flags}, 16'd0);
    repeat (25) @(negedge clk);
    check("abort.no_emit", {15'h0, out_valid}, 16'd0);

    issue("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 4'd15, 1'b1, 16'h0000, 1'b1, 4'b0110, 1'b1);
    drain(50);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute-stage controller of the 16-bit core. It accepts a decoded operation from the issue stage over a valid/ready handshake, registers the operands that drive the combinational `alu`, and captures the ALU result and NZCV into an output register for writeback. It also owns the architectural NZCV flags register. `OP_DIV` does not use the ALU path: this block runs it on an internal 16-iteration restoring divider.

## Interface
- WIDTH, 16, datapath width; only 16 is supported.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  issue stage presents an operation.
- in_ready  out  1  block can accept; high only in IDLE.
- in_op  in  5  opcode; `OP_*` encodings from defines.v.
- in_a, in_b  in  16  operands.
- in_rd  in  4  destination register index.
- in_setflags  in  1  update the flags register from this operation.
- alu_op  out  5  registered opcode driving `alu`.
- alu_a, alu_b  out  16  registered operands driving `alu`.
- alu_result  in  16  from `alu`.
- alu_nzcv  in  4  from `alu`; bit order is [3]=N, [2]=Z, [1]=C, [0]=V.
- out_valid  out  1  writeback data valid.
- out_ready  in  1  writeback stage accepts.
- out_result  out  16  result.
- out_rd  out  4  destination index.
- out_we  out  1  register write enable; 0 for `OP_CMP` and unknown opcodes.
- flags  out  4  architectural NZCV register, same bit order as alu_nzcv.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, EXEC, DIV, HOLD.
- Leaving IDLE: on accept (`in_valid & in_ready`), latch op, a, b, rd and setflags.
  - `OP_DIV` goes to DIV, with the divider loaded and the iteration counter set to 0.
  - Every other opcode goes to EXEC, with alu_op/alu_a/alu_b loaded.
- EXEC (one cycle): at the clock edge, capture alu_result into out_result. Capture out_rd, set out_we, assert out_valid, then go to HOLD.
- DIV (16 cycles): one restoring iteration per cycle, counter 0..15. After iteration 15:
  - out_result is the quotient.
  - Go to HOLD.
  - Remainder is discarded.
- Divide by zero (b==0): still takes 16 cycles. Result is 0xFFFF.
- Unsigned divide: 100/7 gives 14.
- HOLD: out_* are held stable while out_ready is low. When out_ready is high, at the edge:
  - out_valid drops.
  - State returns to IDLE.
  - There is no same-cycle re-accept.
- Flags update happens in the cycle out_valid first rises, and only when setflags=1. Otherwise flags are unchanged.
  - `OP_ADD`/`OP_SUB`/`OP_CMP`: flags take alu_nzcv.
  - `OP_DIV`: N = q[15], Z = (q==0), C = 0, V = (b==0).
  - All other known ops: N = result[15], Z = (result==0); C and V are preserved.
  - Unknown opcode: out_result = 0, out_we = 0, flags unchanged.
- alu_op/alu_a/alu_b hold their last values outside EXEC.
- Reset values: state IDLE, in_ready 1 after reset, out_valid 0, out_result 0, out_rd 0, out_we 0, flags 0, alu_op/alu_a/alu_b 0, busy 0.
- Reset mid-operation (EXEC, DIV or HOLD) aborts the operation. No out_valid is produced and flags are not written.

## Timing
- Accept at edge k:
  - Non-DIV: out_valid high from cycle k+2.
  - DIV: out_valid high from cycle k+17.
- Minimum occupancy per operation is 3 cycles (non-DIV) or 18 cycles (DIV), counting accept through the HOLD release edge.
- The ALU path is combinational between registered alu_* and the out_result capture. EXEC exists so that path gets one full cycle.
- in_ready is combinational from state only; it does not depend on in_valid or out_ready.
- in_valid while busy is ignored. The issue stage must hold in_valid and its payload until accepted.
- The flags register is visible updated in the same cycle out_valid rises.

## Test plan
- Overflow add: ADD a=0x7FFF, b=0x0001, setflags=1.
  - out_valid at k+2.
  - out_result 0x8000, out_we 1.
  - flags N=1, Z=0, V=1 (C as reported by alu).
- Compare: CMP a=5, b=5, setflags=1.
  - out_we 0.
  - flags Z=1.
  - No register write.
- Divide: DIV 100/7.
  - busy for 17 cycles.
  - out_result 14 at k+17.
  - With setflags=1, flags N=0, Z=0, C=0, V=0.
- Divide by zero: DIV 1234/0, setflags=1.
  - out_result 0xFFFF at k+17.
  - flags V=1, N=1.
- Backpressure: ADD 3+4 with out_ready held low for 5 cycles.
  - out_result 7 and out_rd stay stable.
  - in_ready stays 0.
  - IDLE is reached one cycle after out_ready rises.
- Reset during divide: assert rst at DIV iteration 8.
  - Next cycle: state IDLE, in_ready 1, out_valid 0, flags 0.
  - Nothing is ever emitted for the aborted divide.
